// File: rtl/cdc_req_arbiter.sv
// cdc_req_arbiter: round-robin sequencer that shares one sclk->dclk synchroniser channel.
// Define CDC_ARB_TIMEOUT_EN to build the WAIT_* watchdog that drives timeout_err.
module cdc_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  sclk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  output logic                  chan_start,
  output logic [WIDTH-1:0]      chan_data,
  output logic [ID_W-1:0]       chan_id,
  input  logic                  chan_busy,
  output logic                  arb_busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  if (NREQ < 2 || NREQ > 16 || (2 ** ID_W) < NREQ || TIMEOUT < 1) begin : g_param_check
    $error("cdc_req_arbiter: illegal parameter combination");
  end

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   grant_idx, grant_lo, grant_hi;
  logic              grant_found, found_hi;
  logic [WIDTH-1:0]  grant_data;
  logic [WIDTH-1:0]  chan_data_nxt;
  logic [ID_W-1:0]   chan_id_nxt, id_inc;
  logic [NREQ-1:0]   req_ack_nxt;
  logic              chan_start_nxt;
  logic              issue, done, expire;

  assign issue = (state == IDLE) && grant_found && !chan_busy;
  assign done  = (state == WAIT_DONE) && !chan_busy;

  // Rotating priority: the lowest requester at or above ptr wins, else the lowest overall.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    found_hi    = 1'b0;
    grant_lo    = '0;
    grant_hi    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_found = 1'b1;
        grant_lo    = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          found_hi = 1'b1;
          grant_hi = ID_W'(i);
        end
      end
    end
    grant_idx  = found_hi ? grant_hi : grant_lo;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_idx) grant_data = req_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Expiry yields to a normal completion landing on the same cycle.
  assign expire = (state != IDLE) && (cnt == CNT_W'(TIMEOUT - 1)) && !done;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (issue)              cnt <= '0;
      else if (state != IDLE) cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      // NOTE: the data/id holding registers are reset too, so outputs read 0 straight out of reset.
      chan_data  <= '0;
      chan_id    <= '0;
      chan_start <= 1'b0;
      req_ack    <= '0;
      arb_busy   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      chan_data  <= chan_data_nxt;
      chan_id    <= chan_id_nxt;
      chan_start <= chan_start_nxt;
      req_ack    <= req_ack_nxt;
      arb_busy   <= (state_nxt != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (issue) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (expire)         state_nxt = IDLE;
        else if (chan_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (done || expire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the round-robin pointer.
  always_comb begin
    id_inc         = (chan_id == ID_W'(NREQ - 1)) ? '0 : chan_id + ID_W'(1);
    ptr_nxt        = (done || expire) ? id_inc : ptr;
    chan_data_nxt  = issue ? grant_data : chan_data;
    chan_id_nxt    = issue ? grant_idx : chan_id;
    chan_start_nxt = issue;
    req_ack_nxt    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ack_nxt[i] = issue && (ID_W'(i) == grant_idx);
    end
  end

endmodule
